eae_unit: RTL and testbench
===========================

Name: eae_unit

Overview:
- Extended Arithmetic Element for the PDP-8 CPU. Performs MUY (multiply) and DVI (divide) iteratively, one quotient/product bit per clock.
- Sits directly upstream of the CPU register-update logic. The CPU selects its outputs through AC_MUL/AC_DVI, MQ_MUL/MQ_DVI and LK_DVI.
- The controller starts an operation with a one-cycle pulse, then waits for done before selecting the result.
- Operands come from the CPU's current AC, MQ and MB registers.

Parameters:
- WIDTH, 12, word width in bits. Only 12 is supported by the CPU; other values are for unit tests.
- ITERS, WIDTH, number of iteration cycles. Derived; must not be overridden.

Ports:
- clock  input  1  system clock, rising edge
- resetN  input  1  asynchronous active-low reset
- start_mul  input  1  one-cycle pulse from controller: begin MUY
- start_dvi  input  1  one-cycle pulse from controller: begin DVI
- ac_in  input  WIDTH  CPU AC at the start cycle
- mq_in  input  WIDTH  CPU MQ at the start cycle
- operand  input  WIDTH  CPU MB at the start cycle (memory operand Y)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: results valid
- ac_mul  output  WIDTH  MUY high word
- mq_mul  output  WIDTH  MUY low word
- ac_dvi  output  WIDTH  DVI remainder
- mq_dvi  output  WIDTH  DVI quotient
- link_dvi  output  1  DVI overflow flag

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-low (resetN).
- Reset values: busy=0, done=0, all data outputs 0, link_dvi=0, state IDLE, counter 0.
- FSM states: IDLE, MUL, DIV, FIN. Iteration counter is 4 bits.
- IDLE:
  - On start_mul, latch ac_in/mq_in/operand and go to MUL.
  - On start_dvi, latch the same and go to DIV.
  - busy=1 from the cycle after the start edge.
- Both starts high in the same cycle: start_mul wins; start_dvi is dropped.
- Starts seen outside IDLE are ignored. No queueing.
- MUL: shift-add.
  - Result {ac_mul,mq_mul} = mq_in*operand + ac_in, as an unsigned 2*WIDTH value.
  - Cannot overflow: max 7777*7777+7777 = 77770000 (octal).
  - Runs exactly ITERS cycles, then goes to FIN.
- DIV: restoring division of dividend {ac_in,mq_in} by operand.
  - Pre-check in the first DIV cycle: if ac_in >= operand (this includes operand==0), set overflow.
    - Go straight to FIN.
    - link_dvi=1, ac_dvi=ac_in, mq_dvi=mq_in.
  - Otherwise run ITERS cycles and go to FIN.
    - mq_dvi = quotient, ac_dvi = remainder, link_dvi=0.
- FIN:
  - done=1 for exactly one cycle; busy=0 in this cycle; next state IDLE.
  - A start seen in FIN is ignored.
- Latency, start edge to done cycle:
  - MUL and non-overflow DIV: ITERS+1 cycles (13).
  - Overflow DIV: 2 cycles.
- Output update rules:
  - Results update only on entry to FIN and hold until the next FIN.
  - ac_mul/mq_mul update only for MUY.
  - ac_dvi/mq_dvi/link_dvi update only for DVI.
  - Intermediate state is held in internal shift registers and is never visible on the outputs.
- Inputs are sampled only at the start cycle; changes during busy are ignored.
- Reset mid-operation: abort immediately, return to reset values, and produce no done.
- All arithmetic is unsigned and modulo 2^WIDTH per word.

Optional Feature:
- Macro: EAE_RADIX4_EN.
- When defined: two bits are processed per cycle.
  - ITERS/2 = 6 iteration cycles; latency 7 cycles (overflow DIV still 2).
  - Counter runs to 6.
  - Results are bit-identical to radix-2.
- When undefined: radix-2 as specified above.
- The controller always waits on done and never counts cycles, so either build works unchanged.

Decomposition:
- CPU_Definitions.pkg:
  - eae_state_t enum {EAE_IDLE, EAE_MUL, EAE_DIV, EAE_FIN}
  - constant EAE_ITERS
- Sub-module eae_div_step: combinational single restoring-division step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
  - Instantiated once, or twice when EAE_RADIX4_EN is defined.
- The multiply step stays inline.

Test Plan:
- MUY basic: ac_in=0000, mq_in=0003, operand=0005 (octal) → after 13 cycles done=1, ac_mul=0000, mq_mul=0017.
- MUY max: ac_in=mq_in=operand=7777 → ac_mul=7777, mq_mul=0000; ac_dvi/mq_dvi/link_dvi unchanged from prior values.
- DVI basic: ac_in=0000, mq_in=0144, operand=0007 → mq_dvi=0016, ac_dvi=0002, link_dvi=0, latency 13.
- DVI overflow and divide-by-zero:
  - ac_in=0005, operand=0005 → done 2 cycles after start, link_dvi=1, ac_dvi=0005, mq_dvi=mq_in.
  - Repeat with operand=0000 → same behaviour.
- Handshake:
  - start_mul and start_dvi pulsed together → MUY result only.
  - start_dvi pulsed mid-MUY → ignored; exactly one done observed.
- Reset mid-operation: deassert resetN 5 cycles after start_mul → busy=0 and outputs zero immediately (asynchronously); no done after release; a fresh MUY then completes correctly.

Source files
------------

// File: rtl/eae_unit_pkg.sv
// Shared definitions for the PDP-8 Extended Arithmetic Element.
package eae_unit_pkg;

  typedef enum logic [1:0] {
    EAE_IDLE = 2'd0,
    EAE_MUL  = 2'd1,
    EAE_DIV  = 2'd2,
    EAE_FIN  = 2'd3
  } eae_state_t;

  localparam int EAE_ITERS = 12;

endpackage

// File: rtl/eae_unit_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module eae_div_step #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             din_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  assign trial = {rem_i, din_i};
  assign diff  = trial - {1'b0, div_i};
  assign q_o   = (trial >= {1'b0, div_i});
  // The partial remainder is always below the divisor, so a failed trial still fits in WIDTH bits.
  assign rem_o = q_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/eae_unit.sv
// PDP-8 EAE: iterative MUY (shift-add) and DVI (restoring division).
// Define EAE_RADIX4_EN to retire two bits per clock instead of one.
module eae_unit
  import eae_unit_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int ITERS = WIDTH
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             start_mul,
  input  logic             start_dvi,
  input  logic [WIDTH-1:0] ac_in,
  input  logic [WIDTH-1:0] mq_in,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ac_mul,
  output logic [WIDTH-1:0] mq_mul,
  output logic [WIDTH-1:0] ac_dvi,
  output logic [WIDTH-1:0] mq_dvi,
  output logic             link_dvi
);

`ifdef EAE_RADIX4_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif
  localparam logic [3:0] LAST_CNT = 4'(ITERS / STEPS);

  eae_state_t       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, op_q, op_d;
  logic [WIDTH-1:0] ac_mul_q, ac_mul_d, mq_mul_q, mq_mul_d;
  logic [WIDTH-1:0] ac_dvi_q, ac_dvi_d, mq_dvi_q, mq_dvi_d;
  logic             link_q, link_d;

  // {hi,lo} holds the running product; one conditional add then shift right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                 input logic [WIDTH-1:0]   y);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, y} : {(WIDTH+1){1'b0}});
    return {sum, p[WIDTH-1:1]};
  endfunction

  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   rem_a, div_hi, div_lo;
  logic               q_a;

  eae_div_step #(.WIDTH(WIDTH)) u_div_a (
    .rem_i (hi_q),
    .din_i (lo_q[WIDTH-1]),
    .div_i (op_q),
    .rem_o (rem_a),
    .q_o   (q_a)
  );

`ifdef EAE_RADIX4_EN
  logic [WIDTH-1:0] rem_b;
  logic             q_b;

  eae_div_step #(.WIDTH(WIDTH)) u_div_b (
    .rem_i (rem_a),
    .din_i (lo_q[WIDTH-2]),
    .div_i (op_q),
    .rem_o (rem_b),
    .q_o   (q_b)
  );

  assign mul_res = mul_step(mul_step({hi_q, lo_q}, op_q), op_q);
  assign div_hi  = rem_b;
  assign div_lo  = {lo_q[WIDTH-3:0], q_a, q_b};
`else
  assign mul_res = mul_step({hi_q, lo_q}, op_q);
  assign div_hi  = rem_a;
  assign div_lo  = {lo_q[WIDTH-2:0], q_a};
`endif

  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    op_d     = op_q;
    ac_mul_d = ac_mul_q;
    mq_mul_d = mq_mul_q;
    ac_dvi_d = ac_dvi_q;
    mq_dvi_d = mq_dvi_q;
    link_d   = link_q;
    case (state_q)
      EAE_IDLE: begin
        if (start_mul || start_dvi) begin
          state_d = start_mul ? EAE_MUL : EAE_DIV;
          cnt_d   = 4'd0;
          hi_d    = ac_in;
          lo_d    = mq_in;
          op_d    = operand;
        end
      end
      EAE_MUL: begin
        {hi_d, lo_d} = mul_res;
        cnt_d        = cnt_inc;
        if (cnt_inc == LAST_CNT) begin
          state_d  = EAE_FIN;
          ac_mul_d = mul_res[2*WIDTH-1:WIDTH];
          mq_mul_d = mul_res[WIDTH-1:0];
        end
      end
      EAE_DIV: begin
        // Overflow test shares the first iteration cycle; it also catches a zero divisor.
        if (cnt_q == 4'd0 && hi_q >= op_q) begin
          state_d  = EAE_FIN;
          ac_dvi_d = hi_q;
          mq_dvi_d = lo_q;
          link_d   = 1'b1;
        end else begin
          hi_d  = div_hi;
          lo_d  = div_lo;
          cnt_d = cnt_inc;
          if (cnt_inc == LAST_CNT) begin
            state_d  = EAE_FIN;
            ac_dvi_d = div_hi;
            mq_dvi_d = div_lo;
            link_d   = 1'b0;
          end
        end
      end
      default: state_d = EAE_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q  <= EAE_IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_q     <= '0;
      ac_mul_q <= '0;
      mq_mul_q <= '0;
      ac_dvi_q <= '0;
      mq_dvi_q <= '0;
      link_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      op_q     <= op_d;
      ac_mul_q <= ac_mul_d;
      mq_mul_q <= mq_mul_d;
      ac_dvi_q <= ac_dvi_d;
      mq_dvi_q <= mq_dvi_d;
      link_q   <= link_d;
    end
  end

  assign busy     = (state_q == EAE_MUL) || (state_q == EAE_DIV);
  assign done     = (state_q == EAE_FIN);
  assign ac_mul   = ac_mul_q;
  assign mq_mul   = mq_mul_q;
  assign ac_dvi   = ac_dvi_q;
  assign mq_dvi   = mq_dvi_q;
  assign link_dvi = link_q;

endmodule

// File: tb/tb_eae_unit.sv
// Directed-vector bench for eae_unit: octal MUY/DVI vectors plus handshake and reset sequences.
module tb_eae_unit;

  localparam int W = 12;
`ifdef EAE_RADIX4_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 13;
`endif

  logic         clock = 1'b0;
  logic         resetN = 1'b1;
  logic         start_mul = 1'b0;
  logic         start_dvi = 1'b0;
  logic [W-1:0] ac_in = '0;
  logic [W-1:0] mq_in = '0;
  logic [W-1:0] operand = '0;
  logic         busy, done, link_dvi;
  logic [W-1:0] ac_mul, mq_mul, ac_dvi, mq_dvi;

  eae_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .resetN    (resetN),
    .start_mul (start_mul),
    .start_dvi (start_dvi),
    .ac_in     (ac_in),
    .mq_in     (mq_in),
    .operand   (operand),
    .busy      (busy),
    .done      (done),
    .ac_mul    (ac_mul),
    .mq_mul    (mq_mul),
    .ac_dvi    (ac_dvi),
    .mq_dvi    (mq_dvi),
    .link_dvi  (link_dvi)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Expected contents of the five result outputs.
  logic [W-1:0] m_acm = '0, m_mqm = '0, m_acd = '0, m_mqd = '0;
  logic         m_lk = 1'b0;

  typedef struct {
    bit           mul;
    logic [W-1:0] ac, mq, y;
    int           lat;
    logic [W-1:0] r_ac, r_mq;
    logic         lk;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, " ac_mul"}, 32'(ac_mul), 32'(m_acm));
    chk({tag, " mq_mul"}, 32'(mq_mul), 32'(m_mqm));
    chk({tag, " ac_dvi"}, 32'(ac_dvi), 32'(m_acd));
    chk({tag, " mq_dvi"}, 32'(mq_dvi), 32'(m_mqd));
    chk({tag, " link_dvi"}, 32'(link_dvi), 32'(m_lk));
  endtask

  // Pulse a start, scramble the operand inputs, and wait (bounded) for done.
  task automatic run_op(input string tag, input bit sm, input bit sd,
                        input logic [W-1:0] ac, input logic [W-1:0] mq,
                        input logic [W-1:0] y, output int lat);
    @(negedge clock);
    ac_in = ac; mq_in = mq; operand = y;
    start_mul = sm; start_dvi = sd;
    @(posedge clock); #1;
    start_mul = 1'b0; start_dvi = 1'b0;
    ac_in = W'($urandom); mq_in = W'($urandom); operand = W'($urandom);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, lat);
    end else begin
      chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
      @(posedge clock); #1;
      chk({tag, " done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int lat;
    int ndone;

    vecs[0] = '{1'b1, 12'o0000, 12'o0003, 12'o0005, LAT, 12'o0000, 12'o0017, 1'b0};
    vecs[1] = '{1'b1, 12'o7777, 12'o7777, 12'o7777, LAT, 12'o7777, 12'o0000, 1'b0};
    vecs[2] = '{1'b0, 12'o0000, 12'o0144, 12'o0007, LAT, 12'o0002, 12'o0016, 1'b0};
    vecs[3] = '{1'b0, 12'o0005, 12'o0123, 12'o0005, 2,   12'o0005, 12'o0123, 1'b1};
    vecs[4] = '{1'b0, 12'o0005, 12'o0456, 12'o0000, 2,   12'o0005, 12'o0456, 1'b1};
    vecs[5] = '{1'b0, 12'o7776, 12'o7777, 12'o7777, LAT, 12'o7776, 12'o7777, 1'b0};
    vecs[6] = '{1'b1, 12'o1234, 12'o0100, 12'o0010, LAT, 12'o0000, 12'o2234, 1'b0};
    vecs[7] = '{1'b1, 12'o0000, 12'o4000, 12'o0002, LAT, 12'o0001, 12'o0000, 1'b0};
    vecs[8] = '{1'b0, 12'o0001, 12'o0000, 12'o0002, LAT, 12'o0000, 12'o4000, 1'b0};
    vecs[9] = '{1'b0, 12'o0003, 12'o1234, 12'o0001, 2,   12'o0003, 12'o1234, 1'b1};

    #1 resetN = 1'b0;
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    check_outs("reset");
    repeat (2) @(negedge clock);
    resetN = 1'b1;

    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      run_op(tag, vecs[i].mul, !vecs[i].mul, vecs[i].ac, vecs[i].mq, vecs[i].y, lat);
      chk({tag, " latency"}, 32'(lat), 32'(vecs[i].lat));
      if (vecs[i].mul) begin
        m_acm = vecs[i].r_ac; m_mqm = vecs[i].r_mq;
      end else begin
        m_acd = vecs[i].r_ac; m_mqd = vecs[i].r_mq; m_lk = vecs[i].lk;
      end
      check_outs(tag);
    end

    // Simultaneous starts: multiply wins, divide outputs untouched.
    run_op("both", 1'b1, 1'b1, 12'o0000, 12'o0002, 12'o0003, lat);
    chk("both latency", 32'(lat), 32'(LAT));
    m_acm = 12'o0000; m_mqm = 12'o0006;
    check_outs("both");

    // A divide start during a multiply is dropped.
    @(negedge clock);
    ac_in = 12'o0000; mq_in = 12'o0011; operand = 12'o0011; start_mul = 1'b1;
    @(negedge clock);
    start_mul = 1'b0;
    repeat (3) @(negedge clock);
    ac_in = 12'o0001; mq_in = 12'o0000; operand = 12'o0002; start_dvi = 1'b1;
    @(negedge clock);
    start_dvi = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) ndone++;
    end
    chk("midmul done_count", 32'(ndone), 32'd1);
    m_acm = 12'o0000; m_mqm = 12'o0121;
    check_outs("midmul");

    // Asynchronous reset in the middle of a multiply.
    @(negedge clock);
    ac_in = 12'o0000; mq_in = 12'o0007; operand = 12'o0007; start_mul = 1'b1;
    @(negedge clock);
    start_mul = 1'b0;
    repeat (4) @(posedge clock);
    #2 resetN = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    m_acm = '0; m_mqm = '0; m_acd = '0; m_mqd = '0; m_lk = 1'b0;
    check_outs("abort");
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (done) ndone++;
    end
    chk("abort done_count", 32'(ndone), 32'd0);
    check_outs("post_abort");

    run_op("fresh", 1'b1, 1'b0, 12'o0000, 12'o0007, 12'o0007, lat);
    chk("fresh latency", 32'(lat), 32'(LAT));
    m_acm = 12'o0000; m_mqm = 12'o0061;
    check_outs("fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
